// File: rtl/checksum2send_pkg.sv
// Shared definitions for the checksum frame transmitter and its receiver twin.
package checksum2send_pkg;

    localparam int unsigned BYTE_W    = 8;
    // Bytes on the wire per frame: payload bytes plus one checksum byte.
    localparam int unsigned FRAME_LEN = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Byte that brings the 8-bit running sum of a frame back to zero.
    function automatic logic [BYTE_W-1:0] frame_checksum(input logic [BYTE_W-1:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/checksum2send_if.sv
// Application / UART-TX side signals of the checksum frame transmitter.
interface checksum2send_if
    import checksum2send_pkg::*;
#(
    parameter int unsigned DATA_BYTES = FRAME_LEN - 1
);

    logic                           Send_Req;
    logic [BYTE_W*DATA_BYTES-1:0]   Data;
    logic                           TX_Done_Sig;
    logic                           TX_En_Sig;
    logic [BYTE_W-1:0]              TX_Data;
    logic                           Busy;
    logic                           Frame_Done;

    modport master (
        output Send_Req, Data, TX_Done_Sig,
        input  TX_En_Sig, TX_Data, Busy, Frame_Done
    );

    modport slave (
        input  Send_Req, Data, TX_Done_Sig,
        output TX_En_Sig, TX_Data, Busy, Frame_Done
    );

endinterface

// File: rtl/checksum2send.sv
// Frame transmitter: sends DATA_BYTES payload bytes MSB first, then a checksum
// byte chosen so the 8-bit sum of the whole frame is zero. Bytes are offered to
// the UART TX one at a time, with GAP_CYCLES idle cycles between them.
module checksum2send
    import checksum2send_pkg::*;
#(
    parameter int unsigned DATA_BYTES = FRAME_LEN - 1,
    parameter int unsigned GAP_CYCLES = 2
)
(
    input  logic          CLK,
    input  logic          RSTn,
    checksum2send_if.slave bus
);

    localparam int unsigned DATA_W = BYTE_W * DATA_BYTES;
    localparam int unsigned IDX_W  = $clog2(DATA_BYTES + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    // Index value at which the checksum byte, not payload, is on the wire.
    localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(DATA_BYTES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [BYTE_W-1:0]   sum_q,   sum_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [GAP_W-1:0]    gap_q,   gap_d;

    logic [BYTE_W-1:0]   tx_byte;
    logic                tx_en;
    logic [BYTE_W-1:0]   tx_data;
    logic                busy;
    logic                frame_done;

    // State register and datapath flops; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            shreg_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            shreg_q <= shreg_d;
            gap_q   <= gap_d;
        end
    end

    // Byte currently offered: top of the shifter for payload, checksum at the end.
    always_comb begin
        tx_byte = shreg_q[DATA_W-1 -: BYTE_W];
        if (idx_q >= CHK_IDX) begin
            tx_byte = frame_checksum(sum_q);
        end
    end

    // Next-state, datapath update and outputs; outputs decode from the state so
    // an asynchronous reset drops them immediately.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        shreg_d    = shreg_q;
        gap_d      = gap_q;
        tx_en      = 1'b0;
        tx_data    = '0;
        busy       = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.Send_Req) begin
                    shreg_d = bus.Data;
                    sum_d   = '0;
                    idx_d   = '0;
                    gap_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_en   = 1'b1;
                tx_data = tx_byte;
                if (bus.TX_Done_Sig) begin
                    sum_d   = sum_q + tx_byte;
                    shreg_d = shreg_q << BYTE_W;
                    idx_d   = idx_q + IDX_W'(1);
                    gap_d   = '0;
                    state_d = (idx_q == CHK_IDX) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                idx_d   = '0;
                sum_d   = '0;
                shreg_d = '0;
                gap_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.TX_En_Sig  = tx_en;
    assign bus.TX_Data    = tx_data;
    assign bus.Busy       = busy;
    assign bus.Frame_Done = frame_done;

endmodule

// File: tb/tb_checksum2send.sv
// Self-checking bench for checksum2send: a UART TX model answers each offered
// byte after a random delay, a monitor records wire bytes and gaps, and every
// frame is compared with a reference built from the frame rules.
module tb_checksum2send;

    localparam int unsigned DB  = 5;
    localparam int unsigned GAP = 2;
    localparam int unsigned DW  = 8 * DB;

    typedef logic [7:0] frame_t [DB+1];

    logic clk;
    logic rst_n;
    logic uart_done;
    logic stray_done;

    int compared   = 0;
    int mismatched = 0;
    int exp_fd     = 0;
    int fd_cnt     = 0;
    int stable_err = 0;
    int uart_min   = 3;
    int uart_max   = 20;

    logic [7:0] wire_q [$];
    int         gap_q  [$];

    checksum2send_if #(.DATA_BYTES(DB)) bus ();

    checksum2send #(.DATA_BYTES(DB), .GAP_CYCLES(GAP)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    assign bus.TX_Done_Sig = uart_done | stray_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART TX model: completes the offered byte N cycles after TX_En rises.
    initial begin
        int n;
        bit alive;
        uart_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.TX_En_Sig === 1'b1) begin
                n = int'($urandom_range(uart_max, uart_min));
                alive = 1'b1;
                for (int i = 1; i < n; i++) begin
                    @(negedge clk);
                    if (bus.TX_En_Sig !== 1'b1) begin
                        alive = 1'b0;
                        break;
                    end
                end
                if (alive) begin
                    uart_done = 1'b1;
                    @(negedge clk);
                    uart_done = 1'b0;
                end
            end
        end
    end

    // Wire monitor: completed bytes, idle run lengths between bytes, stability.
    initial begin
        bit         prev_en;
        logic [7:0] prev_data;
        int         low_cnt;
        prev_en = 1'b0;
        prev_data = '0;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                prev_en = 1'b0;
                low_cnt = 0;
            end else begin
                if (bus.TX_En_Sig === 1'b1) begin
                    if (prev_en && bus.TX_Data !== prev_data) stable_err++;
                    if (low_cnt > 0) gap_q.push_back(low_cnt);
                    low_cnt = 0;
                    if (bus.TX_Done_Sig === 1'b1) wire_q.push_back(bus.TX_Data);
                end else if (bus.Busy === 1'b1) begin
                    low_cnt++;
                end else begin
                    low_cnt = 0;
                end
                if (bus.Frame_Done === 1'b1) fd_cnt++;
                prev_en = (bus.TX_En_Sig === 1'b1);
                prev_data = bus.TX_Data;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: payload bytes MSB first, then the byte making the total a multiple of 256.
    function automatic frame_t model_frame(input logic [DW-1:0] d);
        frame_t f;
        int     total;
        total = 0;
        for (int k = 0; k < DB; k++) begin
            f[k] = 8'((d >> (8 * (DB - 1 - k))) % 256);
            total += int'(f[k]);
        end
        f[DB] = 8'((256 - (total % 256)) % 256);
        return f;
    endfunction

    task automatic wait_frame_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (bus.Frame_Done === 1'b1) seen = 1'b1;
        end
        check({tag, "_frame_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_frame(input logic [DW-1:0] d, input string tag);
        frame_t     f;
        logic [7:0] b;
        int         total;
        int         g;
        logic [DW-1:0] rebuilt;
        #2;
        f = model_frame(d);
        exp_fd++;
        check({tag, "_nbytes"}, 64'(wire_q.size()), 64'(DB + 1));
        total = 0;
        rebuilt = '0;
        for (int k = 0; k <= DB; k++) begin
            if (wire_q.size() > 0) b = wire_q.pop_front();
            else b = 'x;
            check($sformatf("%s_byte%0d", tag, k), 64'(b), 64'(f[k]));
            total += int'(b);
            if (k < DB) rebuilt = (rebuilt << 8) | DW'(b);
        end
        check({tag, "_sum_zero"}, 64'(total % 256), 64'd0);
        check({tag, "_rebuilt"}, 64'(rebuilt), 64'(d));
        check({tag, "_ngaps"}, 64'(gap_q.size()), 64'(DB));
        for (int k = 0; k < DB; k++) begin
            if (gap_q.size() > 0) g = gap_q.pop_front();
            else g = -1;
            check($sformatf("%s_gap%0d", tag, k), 64'(g), 64'(GAP));
        end
        check({tag, "_frame_done_cnt"}, 64'(fd_cnt), 64'(exp_fd));
        check({tag, "_tx_data_stable"}, 64'(stable_err), 64'd0);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit scramble, input bit pokes, input string tag);
        bit found;
        @(negedge clk);
        bus.Send_Req = 1'b1;
        bus.Data = d;
        @(negedge clk);
        bus.Send_Req = 1'b0;
        check({tag, "_en_after_accept"}, 64'(bus.TX_En_Sig), 64'd1);
        check({tag, "_busy_after_accept"}, 64'(bus.Busy), 64'd1);
        if (scramble) bus.Data = ~d ^ DW'({$urandom(), $urandom()});
        if (pokes) begin
            bus.Send_Req = 1'b1;
            @(negedge clk);
            bus.Send_Req = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge clk);
                if (bus.Busy === 1'b1 && bus.TX_En_Sig === 1'b0 && bus.Frame_Done === 1'b0) found = 1'b1;
            end
            check({tag, "_gap_reached"}, 64'(found), 64'd1);
            bus.Send_Req = 1'b1;
            stray_done = 1'b1;
            @(negedge clk);
            bus.Send_Req = 1'b0;
            stray_done = 1'b0;
        end
        wait_frame_done(tag);
        check_frame(d, tag);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] d2;
        bit found;

        rst_n = 1'b0;
        stray_done = 1'b0;
        bus.Send_Req = 1'b0;
        bus.Data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_en", 64'(bus.TX_En_Sig), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_frame_done", 64'(bus.Frame_Done), 64'd0);
        check("rst_tx_data", 64'(bus.TX_Data), 64'd0);
        rst_n = 1'b1;

        send_frame(40'h0102030405, 1'b0, 1'b0, "seq");
        send_frame(40'hFFFFFFFFFF, 1'b0, 1'b0, "ones");
        send_frame(40'h0000000000, 1'b0, 1'b0, "zero");
        send_frame(40'h1357924680, 1'b0, 1'b1, "busy_pokes");
        send_frame(40'h89ABCDEF01, 1'b1, 1'b0, "data_change");

        // Stray completion pulse while idle must not start anything.
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check("idle_stray_busy", 64'(bus.Busy), 64'd0);
        check("idle_stray_bytes", 64'(wire_q.size()), 64'd0);

        // Completion on the very first SEND cycle of every byte.
        uart_min = 1;
        uart_max = 1;
        send_frame(40'h5A5AA5A5C3, 1'b0, 1'b0, "fast_done");
        uart_min = 3;
        uart_max = 20;

        // Send_Req held high across DONE: next frame accepted on first IDLE cycle.
        d  = 40'h0F1E2D3C4B;
        d2 = 40'h7766554433;
        @(negedge clk);
        bus.Send_Req = 1'b1;
        bus.Data = d;
        @(negedge clk);
        bus.Data = d2;
        wait_frame_done("held1");
        check_frame(d, "held1");
        @(negedge clk);
        check("held_idle_busy", 64'(bus.Busy), 64'd0);
        @(negedge clk);
        check("held_reaccept_busy", 64'(bus.Busy), 64'd1);
        check("held_reaccept_en", 64'(bus.TX_En_Sig), 64'd1);
        bus.Send_Req = 1'b0;
        wait_frame_done("held2");
        check_frame(d2, "held2");

        // Reset while the third byte is offered.
        @(negedge clk);
        bus.Send_Req = 1'b1;
        bus.Data = 40'h1122334455;
        @(negedge clk);
        bus.Send_Req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            #2;
            if (wire_q.size() == 2 && bus.TX_En_Sig === 1'b1) found = 1'b1;
        end
        check("mid_reset_third_byte_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_tx_en", 64'(bus.TX_En_Sig), 64'd0);
        check("mid_reset_busy", 64'(bus.Busy), 64'd0);
        check("mid_reset_tx_data", 64'(bus.TX_Data), 64'd0);
        repeat (3) @(negedge clk);
        wire_q.delete();
        gap_q.delete();
        rst_n = 1'b1;
        send_frame(40'hA0B0C0D0E0, 1'b0, 1'b0, "after_reset");
        repeat (10) @(negedge clk);
        #2;
        check("after_reset_no_leftover", 64'(wire_q.size()), 64'd0);

        // Randomised payloads, occasionally disturbed while in flight.
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < DB; k++) d[8*k +: 8] = 8'($urandom_range(255, 0));
            send_frame(d, (f % 3) == 0, (f % 10) == 0, $sformatf("rand%0d", f));
        end

        repeat (10) @(negedge clk);
        #2;
        check("final_idle_busy", 64'(bus.Busy), 64'd0);
        check("final_no_leftover", 64'(wire_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
